ddr2_cmd_responder: RTL and testbench
=====================================

// Module: ddr2_cmd_responder
// PURPOSE
//  Memory-side counterpart of the DDR2 controller: decodes the DRAM command bus
//  (cke/cs_n/ras_n/cas_n/we_n/ba/addr), captures MR/EMR1-3 contents, tracks the
//  JEDEC init sequence, per-bank open state and tMRD/tRP/tRFC/tRCD spacing.
//  Flags protocol violations.
//  Used in bench/FPGA bring-up between the controller and the DRAM pins.
// PARAMETERS
//  BA_BITS    3   bank address width (2**BA_BITS banks)
//  ADDR_BITS  14  row/column/mode address width
//  TMRD_CK    2   min clocks after LOAD before the next command
//  TRP_CK     3   min clocks after PRE before the next command
//  TRFC_CK    17  min clocks after REF before the next command
//  TRCD_CK    3   min clocks ACT->RD/WR to the same bank
// PORTS
//  clk        in   1          command sample clock (controller's ck edge)
//  rst_n      in   1          asynchronous active-low reset
//  cke        in   1          clock enable from controller
//  cs_n       in   1          chip select
//  ras_n      in   1          row strobe
//  cas_n      in   1          column strobe
//  we_n       in   1          write enable
//  ba         in   BA_BITS    bank address
//  addr       in   ADDR_BITS  address / mode-register payload
//  cmd_valid  out  1          pulse: a non-NOP command was decoded
//  cmd_code   out  3          {ras_n,cas_n,we_n} of the decoded command
//  mr         out  ADDR_BITS  last value loaded to MR   (ba==0)
//  emr1       out  ADDR_BITS  last value loaded to EMR1 (ba==1)
//  emr2       out  ADDR_BITS  last value loaded to EMR2 (ba==2)
//  emr3       out  ADDR_BITS  last value loaded to EMR3 (ba==3)
//  bank_open  out  2**BA_BITS one bit per bank, 1 = row active
//  init_done  out  1          init sequence completed, normal ops allowed
//  err_valid  out  1          pulse: violation detected on this command
//  err_code   out  4          code of the violation (held until next error)
//  err_count  out  8          saturating violation count (stops at 255)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=WAIT_CKE, timers 0, bank_open=0.
//  - Command sampled at posedge clk iff cke=1 and cs_n=0.
//    Commands with {ras,cas,we}=111 are NOP. Outputs are registered (latency 1).
//  - Encodings: LOAD=000 REF=001 PRE=010 ACT=011 WR=100 RD=101 NOP=111.
//  - Init FSM:
//    WAIT_CKE -(cke=1)-> WAIT_PREA -(PRE, addr[10]=1)-> LOAD_EMR;
//    LOAD_EMR: exit once EMR2, EMR3, EMR1 and MR are each loaded -> WAIT_PREA2;
//    WAIT_PREA2 -(PRE all)-> WAIT_REF;
//    WAIT_REF: exit after 2 REFs -> WAIT_MR -(LOAD ba=0)-> WAIT_EMR;
//    WAIT_EMR: exit after two EMR1 loads (OCD default, then exit) -> READY.
//    READY asserts init_done. RD/WR/ACT seen before READY -> err 1 (INIT_ORDER).
//  - Busy timer loads TMRD_CK-1 / TRP_CK-1 / TRFC_CK-1 after LOAD / PRE / REF.
//    It decrements to 0. Any non-NOP while busy != 0 -> err 2 (TIMING).
//    The command is still applied.
//  - Per-bank tRCD timer loads TRCD_CK-1 on ACT.
//    RD/WR to that bank while nonzero -> err 3.
//  - Bank rules:
//    ACT to an open bank -> err 4.
//    RD/WR to a closed bank -> err 5.
//    REF with any bank open -> err 6.
//    PRE: addr[10]=1 clears all bank_open bits, else clears bank ba.
//  - LOAD with ba>=4 is ignored, no error.
//    Same-cycle collisions are checked against pre-command state.
//  - If several errors occur on one command, the lowest code is reported;
//    err_count increments by 1.
//  - cke=0 after READY: commands are ignored and timers keep counting.
//    rst_n low mid-sequence returns to WAIT_CKE immediately (async).
// STRUCTURE
//  - Shared package ddr2_cmd_pkg: command encodings, FSM state enum, err codes.
//    The controller imports the same encodings.
//  - Sub-module ddr2_bank_tracker: open bits and tRCD timers for all banks,
//    with ACT/PRE/access checks.
// TESTING
//  1. Full legal init (controller sequence) -> init_done=1; mr=0x0A52 as loaded;
//     err_count=0.
//  2. REF then ACT 5 clocks later with TRFC_CK=17 -> err_valid pulse,
//     err_code=2, err_count=1.
//  3. After init: ACT b3, RD b3 after 1 clk -> err_code=3;
//     RD after 3 clks -> no error.
//  4. ACT b2 twice -> err_code=4.
//     PRE a10=1, then RD b2 -> err_code=5; bank_open=0.
//  5. RD before init_done, then rst_n low mid-LOAD_EMR -> err_code=1;
//     after reset all outputs 0, FSM back at WAIT_CKE.
//  6. 300 forced violations -> err_count saturates at 255.

Source files
------------

// File: rtl/ddr2_cmd_pkg.sv
// Shared DDR2 command encodings, init-sequence states and violation codes.
// The controller imports the same encodings so both sides agree on the bus.
package ddr2_cmd_pkg;

  // {ras_n, cas_n, we_n}
  typedef enum logic [2:0] {
    CmdLoad = 3'b000,
    CmdRef  = 3'b001,
    CmdPre  = 3'b010,
    CmdAct  = 3'b011,
    CmdWr   = 3'b100,
    CmdRd   = 3'b101,
    CmdNop  = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    StWaitCke,
    StWaitPrea,
    StLoadEmr,
    StWaitPrea2,
    StWaitRef,
    StWaitMr,
    StWaitEmr,
    StReady
  } init_state_e;

  localparam logic [3:0] ErrNone      = 4'd0;
  localparam logic [3:0] ErrInitOrder = 4'd1;
  localparam logic [3:0] ErrTiming    = 4'd2;
  localparam logic [3:0] ErrTrcd      = 4'd3;
  localparam logic [3:0] ErrActOpen   = 4'd4;
  localparam logic [3:0] ErrClosed    = 4'd5;
  localparam logic [3:0] ErrRefOpen   = 4'd6;

endpackage

// File: rtl/ddr2_cmd_responder_if.sv
// DRAM command bus plus the responder's status outputs.
// master = controller side (drives the command pins), slave = responder.
interface ddr2_cmd_responder_if #(
  parameter int unsigned BA_BITS   = 3,
  parameter int unsigned ADDR_BITS = 14
);

  logic                    cke;
  logic                    cs_n;
  logic                    ras_n;
  logic                    cas_n;
  logic                    we_n;
  logic [BA_BITS-1:0]      ba;
  logic [ADDR_BITS-1:0]    addr;

  logic                    cmd_valid;
  logic [2:0]              cmd_code;
  logic [ADDR_BITS-1:0]    mr;
  logic [ADDR_BITS-1:0]    emr1;
  logic [ADDR_BITS-1:0]    emr2;
  logic [ADDR_BITS-1:0]    emr3;
  logic [2**BA_BITS-1:0]   bank_open;
  logic                    init_done;
  logic                    err_valid;
  logic [3:0]              err_code;
  logic [7:0]              err_count;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, ba, addr,
    input  cmd_valid, cmd_code, mr, emr1, emr2, emr3, bank_open, init_done,
           err_valid, err_code, err_count
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, ba, addr,
    output cmd_valid, cmd_code, mr, emr1, emr2, emr3, bank_open, init_done,
           err_valid, err_code, err_count
  );

endinterface

// File: rtl/ddr2_bank_tracker.sv
// Per-bank open-row bits and tRCD countdowns, plus the bank-state checks
// for the command currently on the bus (evaluated on pre-command state).
module ddr2_bank_tracker #(
  parameter int unsigned BA_BITS = 3,
  parameter int unsigned TRCD_CK = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_act,
  input  logic                  i_pre,
  input  logic                  i_pre_all,
  input  logic                  i_access,
  input  logic [BA_BITS-1:0]    i_ba,
  output logic [2**BA_BITS-1:0] o_bank_open,
  output logic                  o_any_open,
  output logic                  o_err_trcd,
  output logic                  o_err_act_open,
  output logic                  o_err_closed
);

  localparam int unsigned NumBanks = 2**BA_BITS;
  localparam int unsigned TrcdW    = (TRCD_CK > 1) ? $clog2(TRCD_CK) : 1;
  localparam logic [TrcdW-1:0] TrcdLoad = TrcdW'(TRCD_CK - 1);

  logic [NumBanks-1:0]             r_bank_open;
  logic [NumBanks-1:0][TrcdW-1:0]  r_trcd;

  assign o_bank_open    = r_bank_open;
  assign o_any_open     = |r_bank_open;
  assign o_err_act_open = i_act & r_bank_open[i_ba];
  assign o_err_closed   = i_access & ~r_bank_open[i_ba];
  assign o_err_trcd     = i_access & (r_trcd[i_ba] != '0);

  // Open bits follow ACT/PRE; tRCD timers reload on ACT and free-run down to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_open <= '0;
      r_trcd      <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (i_act && (i_ba == BA_BITS'(b))) begin
          r_trcd[b] <= TrcdLoad;
        end else if (r_trcd[b] != '0) begin
          r_trcd[b] <= r_trcd[b] - 1'b1;
        end
      end
      if (i_pre_all) begin
        r_bank_open <= '0;
      end else if (i_pre) begin
        r_bank_open[i_ba] <= 1'b0;
      end else if (i_act) begin
        r_bank_open[i_ba] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr2_cmd_responder.sv
// Memory-side DDR2 command responder: decodes the command bus, captures
// mode registers, follows the JEDEC init sequence and flags protocol
// violations (init order, command spacing, bank state).
module ddr2_cmd_responder
  import ddr2_cmd_pkg::*;
#(
  parameter int unsigned BA_BITS   = 3,
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned TMRD_CK   = 2,
  parameter int unsigned TRP_CK    = 3,
  parameter int unsigned TRFC_CK   = 17,
  parameter int unsigned TRCD_CK   = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  ddr2_cmd_responder_if.slave bus
);

  localparam int unsigned NumBanks = 2**BA_BITS;
  localparam int unsigned BusyMax  =
      (TRFC_CK > TRP_CK) ? ((TRFC_CK > TMRD_CK) ? TRFC_CK : TMRD_CK)
                         : ((TRP_CK > TMRD_CK) ? TRP_CK : TMRD_CK);
  localparam int unsigned BusyW    = $clog2(BusyMax + 1);

  logic [2:0]          w_cmd;
  logic                w_valid, w_load_ign, w_eff;
  logic                w_load, w_ref, w_pre, w_pre_all, w_act, w_access;
  logic                w_err_init, w_err_timing, w_err_trcd, w_err_act_open;
  logic                w_err_closed, w_err_ref_open, w_any_open;
  logic [3:0]          w_err_code;
  logic                w_err;
  logic [3:0]          w_ld_bit;
  logic [NumBanks-1:0] w_bank_open;

  init_state_e         r_state, w_state_next;
  logic [3:0]          r_loaded, w_loaded_next;
  logic                r_ref_seen, w_ref_seen_next;
  logic                r_emr1_seen, w_emr1_seen_next;
  logic [BusyW-1:0]    r_busy;

  logic                 r_cmd_valid;
  logic [2:0]           r_cmd_code;
  logic [ADDR_BITS-1:0] r_mr, r_emr1, r_emr2, r_emr3;
  logic                 r_err_valid;
  logic [3:0]           r_err_code;
  logic [7:0]           r_err_count;

  assign w_cmd      = {bus.ras_n, bus.cas_n, bus.we_n};
  assign w_valid    = bus.cke & ~bus.cs_n & (w_cmd != CmdNop);
  // LOAD to a nonexistent mode register is decoded but has no effect at all
  assign w_load_ign = w_valid & (w_cmd == CmdLoad) & (32'(bus.ba) >= 32'd4);
  assign w_eff      = w_valid & ~w_load_ign;
  assign w_load     = w_eff & (w_cmd == CmdLoad);
  assign w_ref      = w_eff & (w_cmd == CmdRef);
  assign w_pre      = w_eff & (w_cmd == CmdPre);
  assign w_pre_all  = w_pre & bus.addr[10];
  assign w_act      = w_eff & (w_cmd == CmdAct);
  assign w_access   = w_eff & ((w_cmd == CmdRd) | (w_cmd == CmdWr));
  assign w_ld_bit   = 4'(1) << bus.ba[1:0];

  ddr2_bank_tracker #(
    .BA_BITS (BA_BITS),
    .TRCD_CK (TRCD_CK)
  ) u_bank_tracker (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_act          (w_act),
    .i_pre          (w_pre),
    .i_pre_all      (w_pre_all),
    .i_access       (w_access),
    .i_ba           (bus.ba),
    .o_bank_open    (w_bank_open),
    .o_any_open     (w_any_open),
    .o_err_trcd     (w_err_trcd),
    .o_err_act_open (w_err_act_open),
    .o_err_closed   (w_err_closed)
  );

  assign w_err_init     = (w_act | w_access) & (r_state != StReady);
  assign w_err_timing   = w_eff & (r_busy != '0);
  assign w_err_ref_open = w_ref & w_any_open;

  // Lowest violation code wins when several fire on one command
  always_comb begin
    w_err_code = ErrNone;
    if (w_err_init)          w_err_code = ErrInitOrder;
    else if (w_err_timing)   w_err_code = ErrTiming;
    else if (w_err_trcd)     w_err_code = ErrTrcd;
    else if (w_err_act_open) w_err_code = ErrActOpen;
    else if (w_err_closed)   w_err_code = ErrClosed;
    else if (w_err_ref_open) w_err_code = ErrRefOpen;
  end

  assign w_err = (w_err_code != ErrNone);

  // Init sequence next-state and progress counters
  always_comb begin
    w_state_next     = r_state;
    w_loaded_next    = r_loaded;
    w_ref_seen_next  = r_ref_seen;
    w_emr1_seen_next = r_emr1_seen;
    case (r_state)
      StWaitCke:   if (bus.cke) w_state_next = StWaitPrea;
      StWaitPrea: begin
        w_loaded_next = '0;
        if (w_pre_all) w_state_next = StLoadEmr;
      end
      StLoadEmr: begin
        if (w_load) begin
          w_loaded_next = r_loaded | w_ld_bit;
          if (&(r_loaded | w_ld_bit)) w_state_next = StWaitPrea2;
        end
      end
      StWaitPrea2: begin
        w_ref_seen_next = 1'b0;
        if (w_pre_all) w_state_next = StWaitRef;
      end
      StWaitRef: begin
        if (w_ref) begin
          if (r_ref_seen) w_state_next = StWaitMr;
          else            w_ref_seen_next = 1'b1;
        end
      end
      StWaitMr: begin
        w_emr1_seen_next = 1'b0;
        if (w_load && (bus.ba == BA_BITS'(0))) w_state_next = StWaitEmr;
      end
      StWaitEmr: begin
        // First EMR1 is OCD default, second is OCD exit
        if (w_load && (bus.ba == BA_BITS'(1))) begin
          if (r_emr1_seen) w_state_next = StReady;
          else             w_emr1_seen_next = 1'b1;
        end
      end
      StReady:     w_state_next = StReady;
      default:     w_state_next = StWaitCke;
    endcase
  end

  // Init state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StWaitCke;
      r_loaded    <= '0;
      r_ref_seen  <= 1'b0;
      r_emr1_seen <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_loaded    <= w_loaded_next;
      r_ref_seen  <= w_ref_seen_next;
      r_emr1_seen <= w_emr1_seen_next;
    end
  end

  // Shared busy timer for tMRD/tRP/tRFC; keeps counting while cke is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (w_load) begin
      r_busy <= BusyW'(TMRD_CK - 1);
    end else if (w_pre) begin
      r_busy <= BusyW'(TRP_CK - 1);
    end else if (w_ref) begin
      r_busy <= BusyW'(TRFC_CK - 1);
    end else if (r_busy != '0) begin
      r_busy <= r_busy - 1'b1;
    end
  end

  // Mode register capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mr   <= '0;
      r_emr1 <= '0;
      r_emr2 <= '0;
      r_emr3 <= '0;
    end else if (w_load) begin
      unique case (bus.ba[1:0])
        2'd0: r_mr   <= bus.addr;
        2'd1: r_emr1 <= bus.addr;
        2'd2: r_emr2 <= bus.addr;
        2'd3: r_emr3 <= bus.addr;
      endcase
    end
  end

  // Registered command and violation reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ErrNone;
      r_err_count <= '0;
    end else begin
      r_cmd_valid <= w_valid;
      if (w_valid) r_cmd_code <= w_cmd;
      r_err_valid <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_code  = r_cmd_code;
  assign bus.mr        = r_mr;
  assign bus.emr1      = r_emr1;
  assign bus.emr2      = r_emr2;
  assign bus.emr3      = r_emr3;
  assign bus.bank_open = w_bank_open;
  assign bus.init_done = (r_state == StReady);
  assign bus.err_valid = r_err_valid;
  assign bus.err_code  = r_err_code;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_ddr2_cmd_responder.sv
// Self-checking bench for ddr2_cmd_responder: directed scenarios plus random
// command streams compared against a time-based behavioural model.
module tb_ddr2_cmd_responder;
  import ddr2_cmd_pkg::*;

  localparam int TMRD = 2;
  localparam int TRP  = 3;
  localparam int TRFC = 17;
  localparam int TRCD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr2_cmd_responder_if #(.BA_BITS(3), .ADDR_BITS(14)) bus ();

  ddr2_cmd_responder #(
    .BA_BITS   (3),
    .ADDR_BITS (14),
    .TMRD_CK   (TMRD),
    .TRP_CK    (TRP),
    .TRFC_CK   (TRFC),
    .TRCD_CK   (TRCD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: absolute cycle numbers instead of countdown timers
  int          cyc = 0;
  int          busy_until;
  int          act_t [8];
  bit [7:0]    m_open;
  logic [13:0] m_mode [4];
  int          phase;      // 0..7 along the init sequence, 7 = ready
  bit [3:0]    m_loaded;
  int          refs, emr1s;
  bit          e_cmd_valid, e_err_valid;
  logic [2:0]  e_cmd_code;
  logic [3:0]  e_err_code;
  int          e_err_count;

  function automatic logic [81:0] dut_vec();
    return {bus.cmd_valid, bus.cmd_code, bus.mr, bus.emr1, bus.emr2, bus.emr3,
            bus.bank_open, bus.init_done, bus.err_valid, bus.err_code, bus.err_count};
  endfunction

  function automatic logic [81:0] exp_vec();
    return {e_cmd_valid, e_cmd_code, m_mode[0], m_mode[1], m_mode[2], m_mode[3],
            m_open, (phase == 7), e_err_valid, e_err_code, 8'(e_err_count)};
  endfunction

  task automatic model_reset();
    busy_until = 0;
    for (int b = 0; b < 8; b++) act_t[b] = -1000;
    m_open = '0;
    for (int i = 0; i < 4; i++) m_mode[i] = '0;
    phase = 0; m_loaded = '0; refs = 0; emr1s = 0;
    e_cmd_valid = 0; e_err_valid = 0; e_cmd_code = '0; e_err_code = '0; e_err_count = 0;
  endtask

  task automatic idle_inputs();
    bus.cke = 1'b0; bus.cs_n = 1'b1;
    {bus.ras_n, bus.cas_n, bus.we_n} = 3'b111;
    bus.ba = '0; bus.addr = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one command cycle and advance the model; outputs valid at return
  task automatic step(input bit cke, input bit cs_n, input logic [2:0] c,
                      input logic [2:0] ba, input logic [13:0] addr);
    bit sel, rw;
    int code;
    @(negedge clk);
    bus.cke = cke; bus.cs_n = cs_n;
    {bus.ras_n, bus.cas_n, bus.we_n} = c;
    bus.ba = ba; bus.addr = addr;

    sel = cke && !cs_n && (c != CmdNop);
    e_cmd_valid = 0; e_err_valid = 0;
    if (sel) begin
      e_cmd_valid = 1; e_cmd_code = c;
      if (!(c == CmdLoad && ba >= 4)) begin
        rw = (c == CmdRd) || (c == CmdWr);
        code = 0;
        if ((rw || c == CmdAct) && phase != 7)    code = 1;
        else if (cyc < busy_until)                code = 2;
        else if (rw && (cyc - act_t[ba]) < TRCD)  code = 3;
        else if (c == CmdAct && m_open[ba])       code = 4;
        else if (rw && !m_open[ba])               code = 5;
        else if (c == CmdRef && m_open != 0)      code = 6;
        if (code != 0) begin
          e_err_valid = 1; e_err_code = 4'(code);
          if (e_err_count < 255) e_err_count++;
        end
        case (c)
          CmdLoad: begin m_mode[ba[1:0]] = addr; busy_until = cyc + TMRD; end
          CmdPre: begin
            busy_until = cyc + TRP;
            if (addr[10]) m_open = '0; else m_open[ba] = 1'b0;
          end
          CmdRef: busy_until = cyc + TRFC;
          CmdAct: begin m_open[ba] = 1'b1; act_t[ba] = cyc; end
          default: ;
        endcase
        case (phase)
          1: if (c == CmdPre && addr[10]) phase = 2;
          2: if (c == CmdLoad) begin
               m_loaded[ba[1:0]] = 1'b1;
               if (m_loaded == 4'hF) phase = 3;
             end
          3: if (c == CmdPre && addr[10]) begin phase = 4; refs = 0; end
          4: if (c == CmdRef) begin refs++; if (refs == 2) phase = 5; end
          5: if (c == CmdLoad && ba == 0) begin phase = 6; emr1s = 0; end
          6: if (c == CmdLoad && ba == 1) begin emr1s++; if (emr1s == 2) phase = 7; end
          default: ;
        endcase
      end
    end
    if (phase == 0 && cke) phase = 1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    repeat (n) step(1, 0, CmdNop, 3'd0, 14'd0);
  endtask

  task automatic do_init();
    nops(2);
    step(1, 0, CmdPre, 3'd0, 14'h0400); nops(2);
    step(1, 0, CmdLoad, 3'd2, 14'h0000); nops(1);
    step(1, 0, CmdLoad, 3'd3, 14'h0000); nops(1);
    step(1, 0, CmdLoad, 3'd1, 14'h0000); nops(1);
    step(1, 0, CmdLoad, 3'd0, 14'h0B52); nops(1);
    step(1, 0, CmdPre, 3'd0, 14'h0400); nops(2);
    step(1, 0, CmdRef, 3'd0, 14'h0000); nops(16);
    step(1, 0, CmdRef, 3'd0, 14'h0000); nops(16);
    step(1, 0, CmdLoad, 3'd0, 14'h0A52); nops(1);
    step(1, 0, CmdLoad, 3'd1, 14'h0380); nops(1);
    step(1, 0, CmdLoad, 3'd1, 14'h0000); nops(1);
  endtask

  task automatic random_step();
    logic [2:0] c;
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0:       c = CmdLoad;
      1:       c = CmdRef;
      2, 3:    c = CmdPre;
      4, 5:    c = CmdAct;
      6:       c = CmdWr;
      7:       c = CmdRd;
      default: c = CmdNop;
    endcase
    step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, c,
         3'($urandom_range(0, 7)), 14'($urandom));
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (dut_vec() !== 82'd0) $display("FAIL reset_outputs: got %h want 0", dut_vec());
    else n_pass++;
  endtask

  task automatic test_init();
    do_init();
    n_checks++;
    if (bus.init_done !== 1'b1) $display("FAIL init_done: got %b want 1", bus.init_done);
    else n_pass++;
    n_checks++;
    if (bus.mr !== 14'h0A52) $display("FAIL init_mr: got %h want 0a52", bus.mr);
    else n_pass++;
    n_checks++;
    if (bus.err_count !== 8'd0) $display("FAIL init_err_count: got %0d want 0", bus.err_count);
    else n_pass++;
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL init_model: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_trfc();
    step(1, 0, CmdRef, 3'd0, 14'd0);
    nops(4);
    step(1, 0, CmdAct, 3'd0, 14'h0123);
    n_checks++;
    if (bus.err_valid !== 1'b1 || bus.err_code !== 4'd2)
      $display("FAIL trfc_err: got valid=%b code=%0d want valid=1 code=2", bus.err_valid, bus.err_code);
    else n_pass++;
    n_checks++;
    if (bus.err_count !== 8'd1) $display("FAIL trfc_count: got %0d want 1", bus.err_count);
    else n_pass++;
    nops(12);
    step(1, 0, CmdPre, 3'd0, 14'd0);
    nops(2);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL trfc_model: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_trcd();
    step(1, 0, CmdAct, 3'd3, 14'h0044);
    step(1, 0, CmdRd, 3'd3, 14'h0010);
    n_checks++;
    if (bus.err_valid !== 1'b1 || bus.err_code !== 4'd3)
      $display("FAIL trcd_early: got valid=%b code=%0d want valid=1 code=3", bus.err_valid, bus.err_code);
    else n_pass++;
    nops(1);
    step(1, 0, CmdRd, 3'd3, 14'h0010);
    n_checks++;
    if (bus.err_valid !== 1'b0 || bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'b101)
      $display("FAIL trcd_ok: got err_valid=%b cmd_valid=%b code=%b want 0 1 101",
               bus.err_valid, bus.cmd_valid, bus.cmd_code);
    else n_pass++;
    step(1, 0, CmdPre, 3'd0, 14'h0400);
    nops(2);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL trcd_model: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_bank_rules();
    step(1, 0, CmdAct, 3'd2, 14'h0001);
    step(1, 0, CmdAct, 3'd2, 14'h0002);
    n_checks++;
    if (bus.err_code !== 4'd4) $display("FAIL act_open: got %0d want 4", bus.err_code);
    else n_pass++;
    step(1, 0, CmdPre, 3'd5, 14'h0400);
    nops(2);
    step(1, 0, CmdRd, 3'd2, 14'h0000);
    n_checks++;
    if (bus.err_code !== 4'd5 || bus.err_valid !== 1'b1)
      $display("FAIL rd_closed: got code=%0d valid=%b want 5 1", bus.err_code, bus.err_valid);
    else n_pass++;
    n_checks++;
    if (bus.bank_open !== 8'h00) $display("FAIL bank_open_clr: got %h want 00", bus.bank_open);
    else n_pass++;
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL bank_model: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_init_order_reset();
    apply_reset();
    nops(1);
    step(1, 0, CmdRd, 3'd0, 14'd0);
    n_checks++;
    if (bus.err_code !== 4'd1) $display("FAIL init_order: got %0d want 1", bus.err_code);
    else n_pass++;
    step(1, 0, CmdPre, 3'd0, 14'h0400); nops(2);
    step(1, 0, CmdLoad, 3'd2, 14'h0011); nops(1);
    step(1, 0, CmdLoad, 3'd3, 14'h0022);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL loademr_model: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    // Asynchronous reset while the clock is low
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== 82'd0) $display("FAIL async_reset: got %h want 0", dut_vec());
    else n_pass++;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, CmdPre, 3'd0, 14'h0400);
    step(0, 0, CmdLoad, 3'd0, 14'h0155);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL post_reset_cke0: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_saturate();
    apply_reset();
    nops(1);
    repeat (300) step(1, 0, CmdRd, 3'd1, 14'd0);
    n_checks++;
    if (bus.err_count !== 8'd255) $display("FAIL err_sat: got %0d want 255", bus.err_count);
    else n_pass++;
    n_checks++;
    if (bus.err_valid !== 1'b1 || bus.err_code !== 4'd1)
      $display("FAIL err_sat_pulse: got valid=%b code=%0d want 1 1", bus.err_valid, bus.err_code);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      random_step();
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL rand_preinit[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    apply_reset();
    do_init();
    for (int i = 0; i < 600; i++) begin
      random_step();
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL rand_ready[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_init();
    test_trfc();
    test_trcd();
    test_bank_rules();
    test_init_order_reset();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
